// File: rtl/neuron_block_param.sv
// Parametrised leaky integrate-and-fire neuron: integrates one timestep of axon
// beats, applies leak, saturates, thresholds, and registers spike/new potential.
module neuron_block_param #(
    parameter int PW         = 8,
    parameter int WW         = 8,
    parameter int N_AXONS    = 256,
    parameter int N_WTYPES   = 4,
    parameter int LEAK_MODE  = 0,
    parameter int RESET_MODE = 0,
    localparam int TW        = (N_WTYPES > 1) ? $clog2(N_WTYPES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic [PW-1:0]          voltage_potential_i,
    input  logic [PW-1:0]          pos_threshold_i,
    input  logic [PW-1:0]          neg_threshold_i,
    input  logic [PW-1:0]          leak_value_i,
    input  logic [PW-1:0]          pos_reset_i,
    input  logic [PW-1:0]          neg_reset_i,
    input  logic [N_WTYPES*WW-1:0] weights_i,
    input  logic                   axon_valid_i,
    input  logic                   axon_spike_i,
    input  logic [TW-1:0]          axon_type_i,
    output logic                   axon_ready_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [PW-1:0]          new_potential_o,
    output logic                   spike_o
);

    // Accumulator is wide enough that N_AXONS worst-case weights cannot overflow it.
    localparam int AW = PW + $clog2(N_AXONS) + 1;
    localparam int CW = $clog2(N_AXONS);
    localparam int WX = (2 ** TW) * WW;

    typedef enum logic [1:0] {IDLE, INTEG, LEAK, FIRE} state_t;

    state_t state, next_state;

    logic [CW-1:0]        beat_count;
    logic signed [AW-1:0] acc;
    logic signed [PW-1:0] pos_thr, neg_thr, pos_rst, neg_rst;
    logic [PW-1:0]        leak;
    logic [WX-1:0]        weights;

    logic                 beat, last_beat;
    logic signed [WW-1:0] w_sel;
    logic signed [AW-1:0] w_ext, leak_ext, diff, acc_leaked, sat_hi, sat_lo;
    logic signed [PW-1:0] v, fire_potential;
    logic                 fire_spike;

    assign axon_ready_o = (state == INTEG) && enable_i;
    assign busy_o       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!enable_i) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (start_i) next_state = INTEG;
                INTEG: if (beat && last_beat) next_state = LEAK;
                LEAK:  next_state = FIRE;
                FIRE:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Weight table is padded to 2**TW entries so out-of-range types select zero.
    always_comb begin
        beat      = axon_valid_i && axon_ready_o;
        last_beat = (beat_count == CW'(N_AXONS - 1));
        w_sel     = weights[axon_type_i*WW +: WW];
        w_ext     = AW'(w_sel);
        leak_ext  = AW'(leak);
        diff      = '0;
        acc_leaked = acc;
        if (LEAK_MODE == 0) begin
            acc_leaked = acc - leak_ext;
        end else if (acc > 0) begin
            diff       = acc - leak_ext;
            acc_leaked = (diff < 0) ? '0 : diff;
        end else if (acc < 0) begin
            diff       = acc + leak_ext;
            acc_leaked = (diff > 0) ? '0 : diff;
        end
    end

    always_comb begin
        sat_hi = AW'(2 ** (PW - 1) - 1);
        sat_lo = AW'(-(2 ** (PW - 1)));
        if (acc > sat_hi)      v = PW'(sat_hi);
        else if (acc < sat_lo) v = PW'(sat_lo);
        else                   v = PW'(acc);
        fire_spike     = 1'b0;
        fire_potential = v;
        if (v >= pos_thr) begin
            fire_spike = 1'b1;
            if (RESET_MODE == 1) fire_potential = v - pos_thr;
            else                 fire_potential = pos_rst;
        end else if (v < neg_thr) begin
            fire_potential = neg_rst;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc             <= '0;
            beat_count      <= '0;
            pos_thr         <= '0;
            neg_thr         <= '0;
            pos_rst         <= '0;
            neg_rst         <= '0;
            leak            <= '0;
            weights         <= '0;
            done_o          <= 1'b0;
            spike_o         <= 1'b0;
            new_potential_o <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && enable_i) begin
                        acc        <= AW'($signed(voltage_potential_i));
                        pos_thr    <= pos_threshold_i;
                        neg_thr    <= neg_threshold_i;
                        pos_rst    <= pos_reset_i;
                        neg_rst    <= neg_reset_i;
                        leak       <= leak_value_i;
                        weights    <= WX'(weights_i);
                        beat_count <= '0;
                    end
                end
                INTEG: begin
                    if (!enable_i) begin
                        beat_count <= '0;
                    end else if (beat) begin
                        if (axon_spike_i) acc <= acc + w_ext;
                        beat_count <= last_beat ? '0 : beat_count + 1'b1;
                    end
                end
                LEAK: begin
                    if (enable_i) acc <= acc_leaked;
                end
                FIRE: begin
                    if (enable_i) begin
                        done_o          <= 1'b1;
                        spike_o         <= fire_spike;
                        new_potential_o <= fire_potential;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_block_param.sv
// Drives two neuron instances (leak/reset modes 0/0 and 1/1) with shared stimulus
// and compares each timestep against a plain-arithmetic reference model.
module tb_neuron_block_param;

    localparam int N = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable_i = 1'b0, start_i = 1'b0;
    logic [7:0] voltage_potential_i = '0, pos_threshold_i = '0, neg_threshold_i = '0;
    logic [7:0] leak_value_i = '0, pos_reset_i = '0, neg_reset_i = '0;
    logic [31:0] weights_i = '0;
    logic axon_valid_i = 1'b0, axon_spike_i = 1'b0;
    logic [1:0] axon_type_i = '0;

    logic ready_a, busy_a, done_a, spike_a;
    logic ready_b, busy_b, done_b, spike_b;
    logic signed [7:0] new_a, new_b;

    int errors = 0;
    int checks = 0;

    int cfg_v0, cfg_leak, cfg_pthr, cfg_nthr, cfg_preset, cfg_nreset;
    int cfg_w[4];
    bit beat_spike[N];
    int beat_type[N];
    int prev_sa = 0, prev_na = 0, prev_sb = 0, prev_nb = 0;

    always #5 clk = ~clk;

    neuron_block_param u_a (
        .clk(clk), .reset(reset), .enable_i(enable_i), .start_i(start_i),
        .voltage_potential_i(voltage_potential_i), .pos_threshold_i(pos_threshold_i),
        .neg_threshold_i(neg_threshold_i), .leak_value_i(leak_value_i),
        .pos_reset_i(pos_reset_i), .neg_reset_i(neg_reset_i), .weights_i(weights_i),
        .axon_valid_i(axon_valid_i), .axon_spike_i(axon_spike_i), .axon_type_i(axon_type_i),
        .axon_ready_o(ready_a), .busy_o(busy_a), .done_o(done_a),
        .new_potential_o(new_a), .spike_o(spike_a)
    );

    neuron_block_param #(.LEAK_MODE(1), .RESET_MODE(1)) u_b (
        .clk(clk), .reset(reset), .enable_i(enable_i), .start_i(start_i),
        .voltage_potential_i(voltage_potential_i), .pos_threshold_i(pos_threshold_i),
        .neg_threshold_i(neg_threshold_i), .leak_value_i(leak_value_i),
        .pos_reset_i(pos_reset_i), .neg_reset_i(neg_reset_i), .weights_i(weights_i),
        .axon_valid_i(axon_valid_i), .axon_spike_i(axon_spike_i), .axon_type_i(axon_type_i),
        .axon_ready_o(ready_b), .busy_o(busy_b), .done_o(done_b),
        .new_potential_o(new_b), .spike_o(spike_b)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic int wrap8(input int x);
        int y;
        y = x & 255;
        return (y > 127) ? y - 256 : y;
    endfunction

    // Reference neuron: integer sum of spiking weights, leak, clamp, threshold.
    function automatic void modelRun(input int leak_mode, input int reset_mode,
                                     output int spk, output int nv);
        int acc, vv;
        acc = cfg_v0;
        for (int i = 0; i < N; i++)
            if (beat_spike[i]) acc += cfg_w[beat_type[i]];
        if (leak_mode == 0) acc -= cfg_leak;
        else if (acc > 0) acc = (acc - cfg_leak < 0) ? 0 : acc - cfg_leak;
        else if (acc < 0) acc = (acc + cfg_leak > 0) ? 0 : acc + cfg_leak;
        vv = (acc > 127) ? 127 : (acc < -128) ? -128 : acc;
        if (vv >= cfg_pthr) begin
            spk = 1;
            nv  = (reset_mode == 1) ? wrap8(vv - cfg_pthr) : cfg_preset;
        end else if (vv < cfg_nthr) begin
            spk = 0;
            nv  = cfg_nreset;
        end else begin
            spk = 0;
            nv  = vv;
        end
    endfunction

    task automatic checkHeld(input string tag);
        checkOutput({tag, "_spike_a"}, spike_a, prev_sa);
        checkOutput({tag, "_new_a"}, new_a, prev_na);
        checkOutput({tag, "_spike_b"}, spike_b, prev_sb);
        checkOutput({tag, "_new_b"}, new_b, prev_nb);
    endtask

    task automatic applyStimulus(input int gap_pct, input bit mid_start,
                                 input int abort_at, input bit reset_in_leak);
        int b, cycles, k, dones;
        bit accepted;
        int esa, ena, esb, enb;
        modelRun(0, 0, esa, ena);
        modelRun(1, 1, esb, enb);
        @(posedge clk); #1;
        voltage_potential_i = 8'(cfg_v0);
        pos_threshold_i     = 8'(cfg_pthr);
        neg_threshold_i     = 8'(cfg_nthr);
        leak_value_i        = 8'(cfg_leak);
        pos_reset_i         = 8'(cfg_preset);
        neg_reset_i         = 8'(cfg_nreset);
        weights_i           = {8'(cfg_w[3]), 8'(cfg_w[2]), 8'(cfg_w[1]), 8'(cfg_w[0])};
        enable_i = 1'b1;
        start_i  = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        voltage_potential_i = 8'($urandom);
        pos_threshold_i     = 8'($urandom);
        neg_threshold_i     = 8'($urandom);
        leak_value_i        = 8'($urandom);
        pos_reset_i         = 8'($urandom);
        neg_reset_i         = 8'($urandom);
        weights_i           = $urandom;
        b = 0; cycles = 0; dones = 0;
        while (b < N && cycles < 4000) begin
            if (b == abort_at) begin
                enable_i     = 1'b0;
                axon_valid_i = 1'b0;
                @(posedge clk); #1;
                checkOutput("abort_busy_a", busy_a, 0);
                checkOutput("abort_busy_b", busy_b, 0);
                repeat (4) begin
                    dones += done_a + done_b;
                    @(posedge clk); #1;
                end
                checkOutput("abort_no_done", dones, 0);
                checkHeld("abort_hold");
                enable_i = 1'b1;
                return;
            end
            if ($urandom_range(99) < gap_pct) begin
                axon_valid_i = 1'b0;
            end else begin
                axon_valid_i = 1'b1;
                axon_spike_i = beat_spike[b];
                axon_type_i  = 2'(beat_type[b]);
            end
            start_i  = mid_start && (cycles == 40);
            accepted = axon_valid_i && ready_a;
            dones   += done_a + done_b;
            @(posedge clk); #1;
            if (accepted) b++;
            cycles++;
        end
        start_i      = 1'b0;
        axon_valid_i = 1'b0;
        checkOutput("beats_accepted", b, N);
        checkOutput("early_done", dones, 0);
        if (reset_in_leak) begin
            reset = 1'b1;
            #1;
            checkOutput("rst_busy_a", busy_a, 0);
            checkOutput("rst_done_a", done_a, 0);
            checkOutput("rst_spike_a", spike_a, 0);
            checkOutput("rst_new_a", new_a, 0);
            checkOutput("rst_spike_b", spike_b, 0);
            checkOutput("rst_new_b", new_b, 0);
            reset = 1'b0;
            prev_sa = 0; prev_na = 0; prev_sb = 0; prev_nb = 0;
            return;
        end
        checkOutput("busy_in_leak", busy_a, 1);
        k = 1;
        while (!done_a && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("done_latency", k, 3);
        checkOutput("done_b", done_b, 1);
        checkOutput("busy_at_done", busy_a, 0);
        checkOutput("spike_a", spike_a, esa);
        checkOutput("new_a", new_a, ena);
        checkOutput("spike_b", spike_b, esb);
        checkOutput("new_b", new_b, enb);
        prev_sa = esa; prev_na = ena; prev_sb = esb; prev_nb = enb;
        @(posedge clk); #1;
        checkOutput("done_one_cycle", done_a + done_b, 0);
        checkOutput("idle_after", busy_a, 0);
        checkHeld("post_hold");
    endtask

    task automatic setBase();
        cfg_v0 = 10; cfg_leak = 5; cfg_pthr = 60; cfg_nthr = -100;
        cfg_preset = 0; cfg_nreset = -50;
        cfg_w[0] = 20; cfg_w[1] = 0; cfg_w[2] = 0; cfg_w[3] = 0;
        for (int i = 0; i < N; i++) begin
            beat_spike[i] = 1'b0;
            beat_type[i]  = int'($urandom_range(3));
        end
    endtask

    task automatic setThreeSpikes();
        setBase();
        beat_spike[5] = 1'b1;   beat_type[5] = 0;
        beat_spike[100] = 1'b1; beat_type[100] = 0;
        beat_spike[255] = 1'b1; beat_type[255] = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", busy_a, 0);
        checkOutput("reset_done", done_a, 0);
        checkOutput("reset_ready", ready_a, 0);
        checkOutput("reset_spike", spike_a, 0);
        checkOutput("reset_new", new_a, 0);
        reset = 1'b0;

        // Three spiking type-0 beats: 10+60-5 = 65 crosses 60.
        setThreeSpikes();
        applyStimulus(0, 1'b0, -1, 1'b0);

        // All beats at +127 saturate; pos_reset 33 distinguishes mode 0.
        setBase();
        cfg_v0 = 100; cfg_pthr = 127; cfg_preset = 33; cfg_w[2] = 127;
        for (int i = 0; i < N; i++) begin beat_spike[i] = 1'b1; beat_type[i] = 2; end
        applyStimulus(0, 1'b0, -1, 1'b0);

        // All beats at -128 saturate low below neg threshold.
        setBase();
        cfg_w[1] = -128;
        for (int i = 0; i < N; i++) begin beat_spike[i] = 1'b1; beat_type[i] = 1; end
        applyStimulus(0, 1'b0, -1, 1'b0);

        // Leak only, starting either side of zero.
        setBase();
        cfg_v0 = -3;
        applyStimulus(0, 1'b0, -1, 1'b0);
        cfg_v0 = 3;
        applyStimulus(0, 1'b0, -1, 1'b0);

        // Random configurations with valid gaps and a stray mid-timestep start.
        for (int r = 0; r < 6; r++) begin
            cfg_v0     = int'($urandom_range(255)) - 128;
            cfg_leak   = int'($urandom_range(40));
            cfg_pthr   = int'($urandom_range(127)) - 40;
            cfg_nthr   = -int'($urandom_range(128));
            cfg_preset = int'($urandom_range(255)) - 128;
            cfg_nreset = int'($urandom_range(255)) - 128;
            for (int k = 0; k < 4; k++) cfg_w[k] = int'($urandom_range(255)) - 128;
            for (int i = 0; i < N; i++) begin
                beat_spike[i] = ($urandom_range(99) < 15);
                beat_type[i]  = int'($urandom_range(3));
            end
            applyStimulus(30, 1'b1, -1, 1'b0);
        end

        // Known result, then an aborted timestep must leave it untouched.
        setThreeSpikes();
        applyStimulus(0, 1'b0, -1, 1'b0);
        setThreeSpikes();
        cfg_v0 = -60;
        applyStimulus(10, 1'b0, 100, 1'b0);

        // Async reset during LEAK clears outputs; then a clean timestep recovers.
        setThreeSpikes();
        applyStimulus(0, 1'b0, -1, 1'b1);
        setThreeSpikes();
        applyStimulus(0, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
